// File: rtl/counter_seq_ctrl.sv
// Switch front-end for the LED counter: 2-flop sync, per-bit debounce, run/hold/load FSM, prescaled step strobe.
// Outputs are registered: step/load strobes lag their decision cycle by one clk; the counter has no backpressure.
module counter_seq_ctrl #(
  parameter int PRESCALE = 100,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] DPSwitch,
  input  logic [7:0] counter_value,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       cnt_load,
  output logic [7:0] load_value,
  output logic [1:0] state
);

  localparam int DBW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam int PSW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [7:0]       sync1, sync2, deb;
  logic [DBW-1:0]   db_cnt [8];
  logic             load_q;
  logic [PSW-1:0]   presc;
  logic             run, stop, load_edge, at_limit, tick, en_nxt;

  // A bit only flips after the synced value has disagreed for DEBOUNCE straight cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      load_q <= 1'b0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= DPSwitch;
      sync2  <= sync1;
      load_q <= deb[2];
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign run       = deb[0];
  assign stop      = deb[3];
  assign load_edge = deb[2] & ~load_q;
  assign at_limit  = cnt_up ? (counter_value == 8'hFF) : (counter_value == 8'h00);
  assign tick      = (state_q == ST_RUN) && (presc == PS_LAST);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_edge)    state_nxt = ST_LOAD;
        else if (run)     state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (load_edge)                     state_nxt = ST_LOAD;
        else if (!run)                     state_nxt = ST_IDLE;
        else if (tick && stop && at_limit) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (load_edge)     state_nxt = ST_LOAD;
        else if (!run)     state_nxt = ST_IDLE;
        else if (!at_limit) state_nxt = ST_RUN;
      end
      ST_LOAD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A tick only steps if the FSM stays in RUN, so run-drop or load on the tick cycle suppresses it.
  assign en_nxt = tick && (state_nxt == ST_RUN) && !(stop && at_limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      presc      <= '0;
      cnt_en     <= 1'b0;
      cnt_load   <= 1'b0;
      cnt_up     <= 1'b0;
      load_value <= 8'h00;
    end else begin
      state_q    <= state_nxt;
      cnt_en     <= en_nxt;
      cnt_load   <= (state_nxt == ST_LOAD);
      cnt_up     <= deb[1];
      load_value <= {deb[7:4], 4'h0};
      if (state_q == ST_RUN && state_nxt == ST_RUN)
        presc <= (presc == PS_LAST) ? '0 : presc + PSW'(1);
      else
        presc <= '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 8-bit counter closing the feedback loop.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] DPSwitch = 8'hFF;
  logic [7:0] counter_value;
  logic       cnt_en, cnt_up, cnt_load;
  logic [7:0] load_value;
  logic [1:0] state;

  logic       preset_vld = 1'b0;
  logic [7:0] preset_val = 8'h00;
  logic [7:0] ctr;

  int n_checks = 0;
  int n_fail   = 0;

  counter_seq_ctrl #(.PRESCALE(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .DPSwitch(DPSwitch), .counter_value(counter_value),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .load_value(load_value), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset)          ctr <= 8'h00;
    else if (preset_vld) ctr <= preset_val;
    else if (cnt_load)   ctr <= load_value;
    else if (cnt_en)     ctr <= cnt_up ? ctr + 8'd1 : ctr - 8'd1;
  end
  assign counter_value = ctr;

  task automatic preset(input logic [7:0] v);
    preset_val = v;
    preset_vld = 1'b1;
    @(negedge clk);
    preset_vld = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    reset = 1'b0;
    DPSwitch = 8'hFF;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({cnt_en, cnt_up, cnt_load, load_value} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 000", {cnt_en, cnt_up, cnt_load, load_value});
    end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    reset = 1'b1;
    wait_state(2'd3, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_load_seen: LOAD not reached in 20 cycles, state %0d", state); end
    n_checks++;
    if (cnt_load !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_load: got %b want 1", cnt_load); end
    n_checks++;
    if (load_value !== 8'hF0) begin n_fail++; $display("FAIL reset_load_value: got %h want f0", load_value); end
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_then_idle: got %0d want 0", state); end
    n_checks++;
    if (ctr !== 8'hF0) begin n_fail++; $display("FAIL reset_loaded_ctr: got %h want f0", ctr); end
    @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL reset_then_run: got %0d want 1", state); end
  endtask

  task automatic test_count_up;
    bit ok;
    int npulse, p0, p1;
    DPSwitch = 8'h00;
    wait_state(2'd0, 30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL up_idle: got state %0d want 0", state); end
    preset(8'h00);
    DPSwitch = 8'h03;
    wait_state(2'd1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL up_run: got state %0d want 1", state); end
    npulse = 0; p0 = -1; p1 = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (cnt_en === 1'b1) begin
        if (npulse == 0) p0 = i;
        if (npulse == 1) p1 = i;
        npulse++;
      end
    end
    n_checks++;
    if (p0 !== 4) begin n_fail++; $display("FAIL up_first_step: got cycle %0d want 4", p0); end
    n_checks++;
    if (p1 - p0 !== 4) begin n_fail++; $display("FAIL up_step_gap: got %0d want 4", p1 - p0); end
    n_checks++;
    if (npulse !== 4) begin n_fail++; $display("FAIL up_pulse_count: got %0d want 4", npulse); end
    n_checks++;
    if (ctr !== 8'h03) begin n_fail++; $display("FAIL up_ctr: got %h want 03", ctr); end
    n_checks++;
    if (cnt_up !== 1'b1) begin n_fail++; $display("FAIL up_dir: got %b want 1", cnt_up); end
  endtask

  task automatic test_stop_hold;
    bit ok;
    int n;
    DPSwitch = 8'h0B;
    repeat (8) @(negedge clk);
    preset(8'hFE);
    wait_state(2'd2, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_reached: got state %0d want 2", state); end
    n_checks++;
    if (ctr !== 8'hFF) begin n_fail++; $display("FAIL hold_ctr: got %h want ff", ctr); end
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cnt_en === 1'b1) n++;
    end
    n_checks++;
    if (n !== 0 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL hold_quiet: got %0d steps state %0d want 0 steps state 2", n, state);
    end
    DPSwitch = 8'h09;
    wait_state(2'd1, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_resume: got state %0d want 1", state); end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cnt_en === 1'b1) n++;
      if (n == 2) break;
    end
    @(negedge clk);
    n_checks++;
    if (ctr !== 8'hFD) begin n_fail++; $display("FAIL down_ctr: got %h want fd", ctr); end
    n_checks++;
    if (cnt_up !== 1'b0) begin n_fail++; $display("FAIL down_dir: got %b want 0", cnt_up); end
  endtask

  task automatic test_wrap;
    bit got;
    DPSwitch = 8'h03;
    repeat (8) @(negedge clk);
    n_checks++;
    if (cnt_up !== 1'b1) begin n_fail++; $display("FAIL wrap_dir: got %b want 1", cnt_up); end
    preset(8'hFF);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cnt_en === 1'b1) begin got = 1'b1; break; end
    end
    @(negedge clk);
    n_checks++;
    if (!got || ctr !== 8'h00) begin n_fail++; $display("FAIL wrap_ctr: got %h step %b want 00 step 1", ctr, got); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL wrap_state: got %0d want 1", state); end
  endtask

  task automatic test_load;
    bit ok;
    int extra;
    DPSwitch = 8'hA1;
    repeat (8) @(negedge clk);
    DPSwitch = 8'hA5;
    wait_state(2'd3, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_state: got %0d want 3", state); end
    n_checks++;
    if (cnt_load !== 1'b1) begin n_fail++; $display("FAIL load_strobe: got %b want 1", cnt_load); end
    n_checks++;
    if (load_value !== 8'hA0) begin n_fail++; $display("FAIL load_value: got %h want a0", load_value); end
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL load_to_idle: got %0d want 0", state); end
    n_checks++;
    if (ctr !== 8'hA0) begin n_fail++; $display("FAIL load_ctr: got %h want a0", ctr); end
    extra = (cnt_load === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (cnt_load === 1'b1) extra++;
    end
    DPSwitch = 8'hA1;
    repeat (10) begin
      @(negedge clk);
      if (cnt_load === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL load_single: got %0d extra loads want 0", extra); end
  endtask

  task automatic test_glitch;
    bit ok;
    int bad, strobes;
    DPSwitch = 8'h00;
    wait_state(2'd0, 20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL glitch_idle: got state %0d want 0", state); end
    repeat (6) @(negedge clk);
    DPSwitch = 8'h05;
    repeat (2) @(negedge clk);
    DPSwitch = 8'h00;
    bad = 0; strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (state !== 2'd0) bad++;
      if (cnt_en === 1'b1 || cnt_load === 1'b1) strobes++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL glitch_state: got %0d non-idle cycles want 0", bad); end
    n_checks++;
    if (strobes !== 0) begin n_fail++; $display("FAIL glitch_strobe: got %0d strobes want 0", strobes); end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    DPSwitch = 8'hF3;
    wait_state(2'd1, 20, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || load_value !== 8'hF0 || cnt_up !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: got state %0d lv %h up %b want 1 f0 1", state, load_value, cnt_up);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({cnt_en, cnt_up, cnt_load, load_value} !== 11'h000) begin
      n_fail++;
      $display("FAIL midrun_outputs: got %h want 000", {cnt_en, cnt_up, cnt_load, load_value});
    end
    n_checks++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL midrun_state: got %0d want 0", state); end
    DPSwitch = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (state !== 2'd0 || cnt_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_after: got state %0d en %b want 0 0", state, cnt_en);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_stop_hold();
    test_wrap();
    test_load();
    test_glitch();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
